// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: pending-call bitmaps with an IDLE/UP/DOWN
// sweep controller that picks the next stop from the registered calls.
module elevator_request_scheduler #(
    parameter int FLOOR_COUNT = 8,
    parameter int FLOOR_W = 3,
    localparam int CNT_W = $clog2(3 * FLOOR_COUNT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [1:0]             req_type,
    input  logic [FLOOR_W-1:0]     req_floor,
    input  logic [FLOOR_W-1:0]     current_floor,
    input  logic                   arrived,
    output logic [FLOOR_COUNT-1:0] car_q,
    output logic [FLOOR_COUNT-1:0] up_q,
    output logic [FLOOR_COUNT-1:0] dn_q,
    output logic [1:0]             direction,
    output logic                   dest_valid,
    output logic [FLOOR_W-1:0]     dest_floor,
    output logic [CNT_W-1:0]       pending_count
);
    typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} state_t;
    state_t state, state_n;
    logic [FLOOR_COUNT-1:0] req_oh, cur_oh, above, below, pend;
    logic [FLOOR_COUNT-1:0] req_car, req_up, req_dn, cancel, arr;
    logic [FLOOR_COUNT-1:0] car_n, up_n, dn_n;
    logic [FLOOR_W-1:0] up_sel, dn_sel, dest_n;
    logic any_up, any_dn, dv_n;
    assign direction = state;
    always_comb begin
        req_oh = '0;
        cur_oh = '0;
        above = '0;
        below = '0;
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            req_oh[i] = req_floor == FLOOR_W'(i);
            cur_oh[i] = current_floor == FLOOR_W'(i);
            above[i] = FLOOR_W'(i) > current_floor;
            below[i] = FLOOR_W'(i) < current_floor;
        end
        // out-of-range floors leave req_oh empty, so they are dropped for free
        req_car = (req_valid && req_type == 2'b00) ? req_oh : '0;
        req_up = (req_valid && req_type == 2'b01 && !req_oh[FLOOR_COUNT-1]) ? req_oh : '0;
        req_dn = (req_valid && req_type == 2'b10 && !req_oh[0]) ? req_oh : '0;
        cancel = (req_valid && req_type == 2'b11) ? req_oh : '0;
        arr = arrived ? cur_oh : '0;
        car_n = (car_q | req_car) & ~(cancel | arr);
        up_n = (up_q | req_up) & ~(cancel | ((state != DOWN) ? arr : '0));
        dn_n = (dn_q | req_dn) & ~(cancel | ((state != UP) ? arr : '0));
        pend = car_q | up_q | dn_q;
        any_up = |(pend & above);
        any_dn = |(pend & below);
        state_n = (state == DOWN) ? (any_dn ? DOWN : any_up ? UP : IDLE)
                                  : (any_up ? UP : any_dn ? DOWN : IDLE);
        up_sel = '0;
        dn_sel = '0;
        for (int i = FLOOR_COUNT - 1; i >= 0; i--)
            if (pend[i] && above[i]) up_sel = FLOOR_W'(i);
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (pend[i] && below[i]) dn_sel = FLOOR_W'(i);
        dv_n = (state_n != IDLE) || |(pend & cur_oh);
        dest_n = (state_n == UP) ? up_sel : (state_n == DOWN) ? dn_sel : current_floor;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            car_q <= '0;
            up_q <= '0;
            dn_q <= '0;
            pending_count <= '0;
            state <= IDLE;
            dest_valid <= 1'b0;
            dest_floor <= '0;
        end else begin
            car_q <= car_n;
            up_q <= up_n;
            dn_q <= dn_n;
            pending_count <= CNT_W'($countones({car_n, up_n, dn_n}));
            state <= state_n;
            dest_valid <= dv_n;
            if (dv_n) dest_floor <= dest_n;
        end
    end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb_elevator_request_scheduler: directed scenarios plus random traffic
// checked against a floor-by-floor reference model.
module tb_elevator_request_scheduler;
    localparam int N = 8;
    logic clk = 0, reset = 0, req_valid = 0, arrived = 0;
    logic [1:0] req_type = 0;
    logic [3:0] req_floor = 0, current_floor = 0;
    logic [N-1:0] car_q, up_q, dn_q;
    logic [1:0] direction;
    logic dest_valid;
    logic [3:0] dest_floor;
    logic [4:0] pending_count;
    int n_chk = 0, n_fail = 0;
    bit mc[N], mu[N], md[N];
    int mdir = 0, mdest = 0;
    bit mdv = 0;

    elevator_request_scheduler #(.FLOOR_COUNT(N), .FLOOR_W(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
        .req_floor(req_floor), .current_floor(current_floor), .arrived(arrived),
        .car_q(car_q), .up_q(up_q), .dn_q(dn_q), .direction(direction),
        .dest_valid(dest_valid), .dest_floor(dest_floor), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending(int i);
        return mc[i] | mu[i] | md[i];
    endfunction

    function automatic logic [N-1:0] pack(bit a[N]);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic model_update();
        int cf = int'(current_floor), f = int'(req_floor), ndir, lo = N, hi = -1;
        bit ab = 0, be = 0;
        if (reset) begin
            foreach (mc[i]) begin mc[i] = 0; mu[i] = 0; md[i] = 0; end
            mdir = 0; mdv = 0; mdest = 0;
            return;
        end
        for (int i = 0; i < N; i++) if (pending(i)) begin
            if (i > cf) begin ab = 1; if (i < lo) lo = i; end
            if (i < cf) begin be = 1; if (i > hi) hi = i; end
        end
        if (mdir == 2) ndir = be ? 2 : ab ? 1 : 0;
        else ndir = ab ? 1 : be ? 2 : 0;
        if (ndir == 1) begin mdv = 1; mdest = lo; end
        else if (ndir == 2) begin mdv = 1; mdest = hi; end
        else begin
            mdv = cf < N && pending(cf);
            if (mdv) mdest = cf;
        end
        if (req_valid && f < N) case (req_type)
            2'b00: mc[f] = 1;
            2'b01: if (f != N - 1) mu[f] = 1;
            2'b10: if (f != 0) md[f] = 1;
            default: begin mc[f] = 0; mu[f] = 0; md[f] = 0; end
        endcase
        if (arrived && cf < N) begin
            mc[cf] = 0;
            if (mdir != 2) mu[cf] = 0;
            if (mdir != 1) md[cf] = 0;
        end
        mdir = ndir;
    endtask

    task automatic step(bit rst, bit v, logic [1:0] t, int f, bit arr);
        int cnt = 0;
        reset = rst; req_valid = v; req_type = t; req_floor = 4'(f); arrived = arr;
        model_update();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) cnt += int'(mc[i]) + int'(mu[i]) + int'(md[i]);
        chk("car_q", car_q, pack(mc));
        chk("up_q", up_q, pack(mu));
        chk("dn_q", dn_q, pack(md));
        chk("pending_count", pending_count, cnt);
        chk("direction", direction, mdir);
        chk("dest_valid", dest_valid, mdv);
        chk("dest_floor", dest_floor, mdest);
        reset = 0; req_valid = 0; arrived = 0;
    endtask

    task automatic idle();
        step(0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        current_floor = 0;
        step(1, 0, 2'b00, 0, 0);
        chk("rst_count", pending_count, 0);
        chk("rst_dir", direction, 0);
        chk("rst_dv", dest_valid, 0);
        chk("rst_dest", dest_floor, 0);
        step(0, 1, 2'b00, 5, 0);
        chk("r31_car", car_q, 8'h20);
        chk("r31_count", pending_count, 1);
        idle();
        chk("r31_dir", direction, 1);
        chk("r31_dest", dest_floor, 5);

        step(1, 0, 2'b00, 0, 0);
        current_floor = 2;
        step(0, 1, 2'b00, 4, 0);
        step(0, 1, 2'b00, 6, 0);
        idle();
        chk("r32_dir", direction, 1);
        chk("r32_dest4", dest_floor, 4);
        current_floor = 4;
        step(0, 0, 2'b00, 0, 1);
        chk("r32_car", car_q, 8'h40);
        idle();
        chk("r32_dest6", dest_floor, 6);

        step(1, 0, 2'b00, 0, 0);
        current_floor = 3;
        step(0, 1, 2'b00, 6, 0);
        step(0, 1, 2'b00, 1, 0);
        idle();
        chk("r33_dir_up", direction, 1);
        chk("r33_dest6", dest_floor, 6);
        current_floor = 6;
        step(0, 0, 2'b00, 0, 1);
        idle();
        chk("r33_dir_dn", direction, 2);
        chk("r33_dest1", dest_floor, 1);

        step(1, 0, 2'b00, 0, 0);
        current_floor = 0;
        step(0, 1, 2'b01, 7, 0);
        step(0, 1, 2'b10, 0, 0);
        step(0, 1, 2'b00, 9, 0);
        step(0, 1, 2'b01, 9, 0);
        chk("r34_count", pending_count, 0);
        chk("r34_bitmaps", {car_q, up_q, dn_q}, 0);

        current_floor = 3;
        step(0, 1, 2'b00, 3, 1);
        chk("r35_clrwin", car_q[3], 0);
        current_floor = 0;
        step(0, 1, 2'b00, 5, 0);
        step(0, 1, 2'b01, 5, 0);
        step(0, 1, 2'b10, 5, 0);
        chk("r35_count3", pending_count, 3);
        step(0, 1, 2'b11, 5, 0);
        chk("r35_cancel", {car_q[5], up_q[5], dn_q[5]}, 0);
        chk("r35_count0", pending_count, 0);

        current_floor = 7;
        step(0, 1, 2'b00, 1, 0);
        step(0, 1, 2'b00, 2, 0);
        step(0, 1, 2'b00, 3, 0);
        step(0, 1, 2'b01, 2, 0);
        idle();
        chk("r36_dir", direction, 2);
        chk("r36_count", pending_count, 4);
        step(1, 1, 2'b00, 4, 1);
        chk("r36_count0", pending_count, 0);
        chk("r36_bitmaps", {car_q, up_q, dn_q}, 0);
        chk("r36_dir0", direction, 0);
        chk("r36_dv", dest_valid, 0);

        for (int k = 0; k < 600; k++) begin
            current_floor = 4'($urandom_range(0, 8));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom_range(0, 9), $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
